// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch types: controller state and word address
package core_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    RESUME = 2'd2
  } fetch_ctrl_state_e;

  typedef logic [29:0] word_addr_t;

endpackage

// File: rtl/fencei_walker.sv
// rtl/fencei_walker.sv - walks every icache set through the invalidate port
module fencei_walker
  import core_pkg::*;
#(
  parameter int IC_SETS = 64,
  parameter int SET_W   = $clog2(IC_SETS)
) (
  input  logic             clk_core,
  input  logic             reset_n,
  input  logic             active,
  input  logic             ic_inv_ack,
  output logic             ic_inv_req,
  output logic [SET_W-1:0] ic_inv_set,
  output logic             done
);

  localparam logic [SET_W-1:0] LAST_SET = SET_W'(IC_SETS - 1);

  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic             last;

  assign last       = (set_cnt_q == LAST_SET);
  assign ic_inv_req = active;
  assign ic_inv_set = set_cnt_q;
  assign done       = active & ic_inv_ack & last;

  always_comb begin
    set_cnt_d = set_cnt_q;
    if (!active) begin
      set_cnt_d = '0;
    end else if (ic_inv_ack) begin
      set_cnt_d = last ? '0 : set_cnt_q + SET_W'(1);
    end
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      set_cnt_q <= '0;
    end else begin
      set_cnt_q <= set_cnt_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch0 PC owner: next-PC mux, held redirect, fence.i sequencing
module fetch_ctrl
  import core_pkg::*;
#(
  parameter int         IC_SETS  = 64,
  parameter word_addr_t RESET_PC = 30'h0,
  parameter int         SET_W    = $clog2(IC_SETS)
) (
  input  logic             clk_core,
  input  logic             reset_n,
  input  logic             fe1_stall,
  input  logic             de_setpc,
  input  logic [29:0]      de_newpc,
  input  logic             csr_kill_setpc,
  input  logic [29:0]      csr_newpc,
  input  logic             csr_fe_inhibit,
  input  logic             csr_fencei,
  input  logic [29:0]      csr_fencei_pc,
  input  logic [31:0]      csr_satp,
  output logic             fe0_read_req,
  output logic [8:0]       fe0_read_asid,
  output logic [29:0]      fe0_read_addr,
  output logic             fe0_valid,
  output logic             ic_inv_req,
  output logic [SET_W-1:0] ic_inv_set,
  input  logic             ic_inv_ack,
  output logic             fencei_busy
);

  fetch_ctrl_state_e state_q, state_d;
  word_addr_t        pc_q, pc_d, pend_pc_q, pend_pc_d, next_addr;
  logic              pend_v_q, pend_v_d, pend_csr_q, pend_csr_d;
  logic              run, fence_go, issue, flush_done;

  assign run      = (state_q == RUN);
  assign fence_go = run & csr_fencei;
  assign issue    = run & ~csr_fencei & ~csr_fe_inhibit & (~fe1_stall | csr_kill_setpc);

  // A decode redirect behind a pending CSR redirect comes from a killed path.
  always_comb begin
    if (csr_kill_setpc)                next_addr = csr_newpc;
    else if (de_setpc && !pend_csr_q)  next_addr = de_newpc;
    else if (pend_v_q)                 next_addr = pend_pc_q;
    else                               next_addr = pc_q;
  end

  // Outputs are forced low while reset is asserted, since the mux is combinational.
  assign fe0_read_req  = issue & reset_n;
  assign fe0_valid     = fe0_read_req;
  assign fe0_read_addr = reset_n ? next_addr : '0;
  assign fe0_read_asid = csr_satp[30:22];
  assign fencei_busy   = ~run;

  fencei_walker #(
    .IC_SETS(IC_SETS),
    .SET_W  (SET_W)
  ) u_walker (
    .clk_core  (clk_core),
    .reset_n   (reset_n),
    .active    (state_q == FLUSH),
    .ic_inv_ack(ic_inv_ack),
    .ic_inv_req(ic_inv_req),
    .ic_inv_set(ic_inv_set),
    .done      (flush_done)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    pend_v_d   = pend_v_q;
    pend_csr_d = pend_csr_q;
    if (issue) begin
      pc_d       = next_addr + 30'd1;
      pend_v_d   = 1'b0;
      pend_csr_d = 1'b0;
    end else if (fence_go) begin
      pend_pc_d  = csr_fencei_pc;
      pend_v_d   = 1'b1;
      pend_csr_d = 1'b1;
    end else if (csr_kill_setpc) begin
      pend_pc_d  = csr_newpc;
      pend_v_d   = 1'b1;
      pend_csr_d = 1'b1;
    end else if (de_setpc && !pend_csr_q) begin
      pend_pc_d  = de_newpc;
      pend_v_d   = 1'b1;
    end
    case (state_q)
      RUN:     if (csr_fencei) state_d = FLUSH;
      FLUSH:   if (flush_done) state_d = RESUME;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      pend_v_q   <= 1'b0;
      pend_csr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_v_q   <= pend_v_d;
      pend_csr_q <= pend_csr_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl with a behavioural reference model
module tb_fetch_ctrl;

  localparam int          IC_SETS = 4;
  localparam int          SW      = 2;
  localparam logic [29:0] RST_PC  = 30'h3FFF_FFFD;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          fe1_stall, de_setpc, csr_kill_setpc, csr_fe_inhibit, csr_fencei, ic_inv_ack;
  logic [29:0]   de_newpc, csr_newpc, csr_fencei_pc;
  logic [31:0]   csr_satp;
  logic          fe0_read_req, fe0_valid, ic_inv_req, fencei_busy;
  logic [8:0]    fe0_read_asid;
  logic [29:0]   fe0_read_addr;
  logic [SW-1:0] ic_inv_set;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.IC_SETS(IC_SETS), .RESET_PC(RST_PC)) dut (
    .clk_core(clk), .reset_n(reset_n), .fe1_stall(fe1_stall),
    .de_setpc(de_setpc), .de_newpc(de_newpc),
    .csr_kill_setpc(csr_kill_setpc), .csr_newpc(csr_newpc),
    .csr_fe_inhibit(csr_fe_inhibit), .csr_fencei(csr_fencei),
    .csr_fencei_pc(csr_fencei_pc), .csr_satp(csr_satp),
    .fe0_read_req(fe0_read_req), .fe0_read_asid(fe0_read_asid),
    .fe0_read_addr(fe0_read_addr), .fe0_valid(fe0_valid),
    .ic_inv_req(ic_inv_req), .ic_inv_set(ic_inv_set),
    .ic_inv_ack(ic_inv_ack), .fencei_busy(fencei_busy)
  );

  // Reference model: mode 0=fetching, 1=invalidating, 2=restart gap.
  logic [29:0] m_pc, m_tgt, n_pc, n_tgt;
  bit          m_held, m_from_csr, n_held, n_from_csr;
  int          m_mode, m_set, n_mode, n_set;
  bit          e_req, e_inv, e_busy;
  logic [29:0] e_addr;
  int          e_set;

  task automatic model_reset();
    m_pc = RST_PC; m_tgt = '0; m_held = 0; m_from_csr = 0; m_mode = 0; m_set = 0;
  endtask

  task automatic model_eval();
    bit take_de;
    take_de = de_setpc && !m_from_csr;
    e_req   = reset_n && m_mode == 0 && !csr_fencei && !csr_fe_inhibit && (!fe1_stall || csr_kill_setpc);
    e_addr  = csr_kill_setpc ? csr_newpc : take_de ? de_newpc : m_held ? m_tgt : m_pc;
    e_inv   = reset_n && m_mode == 1;
    e_set   = m_set;
    e_busy  = reset_n && m_mode != 0;
    n_pc = m_pc; n_tgt = m_tgt; n_held = m_held; n_from_csr = m_from_csr;
    n_mode = m_mode; n_set = m_set;
    if (e_req) begin
      n_pc = (e_addr + 30'd1) % (1 << 30);
      n_held = 0; n_from_csr = 0;
    end else if (m_mode == 0 && csr_fencei) begin
      n_tgt = csr_fencei_pc; n_held = 1; n_from_csr = 1; n_mode = 1; n_set = 0;
    end else if (csr_kill_setpc) begin
      n_tgt = csr_newpc; n_held = 1; n_from_csr = 1;
    end else if (take_de) begin
      n_tgt = de_newpc; n_held = 1;
    end
    if (m_mode == 1 && ic_inv_ack) begin
      if (m_set == IC_SETS - 1) begin n_mode = 2; n_set = 0; end
      else n_set = m_set + 1;
    end else if (m_mode == 2) begin
      n_mode = 0;
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      m_pc = n_pc; m_tgt = n_tgt; m_held = n_held; m_from_csr = n_from_csr;
      m_mode = n_mode; m_set = n_set;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    fe1_stall = 0; de_setpc = 0; csr_kill_setpc = 0; csr_fe_inhibit = 0;
    csr_fencei = 0; ic_inv_ack = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle_inputs();
    csr_kill_setpc = 1; csr_newpc = 30'h123; de_newpc = 30'h77; csr_fencei_pc = 30'h0;
    csr_satp = $urandom();
    @(negedge clk);
    settle();
    n_tests++;
    if (fe0_read_req !== 1'b0 || fe0_valid !== 1'b0 || fe0_read_addr !== 30'h0 ||
        ic_inv_req !== 1'b0 || ic_inv_set !== '0 || fencei_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b valid=%b addr=%h inv=%b set=%0d busy=%b, required all 0",
               fe0_read_req, fe0_valid, fe0_read_addr, ic_inv_req, ic_inv_set, fencei_busy);
    end
    n_tests++;
    if (fe0_read_asid !== csr_satp[30:22]) begin
      n_fail++;
      $display("FAIL reset_asid: got %h required %h", fe0_read_asid, csr_satp[30:22]);
    end
    tick();
    csr_kill_setpc = 0;
    reset_n = 1;
    model_reset();
  endtask

  task automatic test_sequential_wrap();
    logic [29:0] want;
    want = RST_PC;
    for (int i = 0; i < 6; i++) begin
      settle();
      n_tests++;
      if (fe0_read_req !== 1'b1 || fe0_read_addr !== want) begin
        n_fail++;
        $display("FAIL seq_wrap[%0d]: req=%b addr=%h, required req=1 addr=%h", i, fe0_read_req, fe0_read_addr, want);
      end
      want = want + 30'd1;
      tick();
    end
  endtask

  task automatic test_stall_redirect();
    fe1_stall = 1; de_setpc = 1; de_newpc = 30'h100;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_tests++;
      if (fe0_read_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_noreq[%0d]: req=%b required 0", i, fe0_read_req);
      end
      tick();
      de_setpc = 0;
    end
    fe1_stall = 0;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_tests++;
      if (fe0_read_req !== 1'b1 || fe0_read_addr !== 30'h100 + 30'(i)) begin
        n_fail++;
        $display("FAIL stall_release[%0d]: req=%b addr=%h required req=1 addr=%h",
                 i, fe0_read_req, fe0_read_addr, 30'h100 + 30'(i));
      end
      tick();
    end
  endtask

  task automatic test_csr_priority();
    fe1_stall = 1; csr_kill_setpc = 1; csr_newpc = 30'h40; de_setpc = 1; de_newpc = 30'h80;
    settle();
    n_tests++;
    if (fe0_read_req !== 1'b1 || fe0_read_addr !== 30'h40) begin
      n_fail++;
      $display("FAIL csr_wins: req=%b addr=%h required req=1 addr=040", fe0_read_req, fe0_read_addr);
    end
    tick();
    idle_inputs();
    csr_fe_inhibit = 1; csr_kill_setpc = 1; csr_newpc = 30'h500;
    settle();
    tick();
    idle_inputs();
    fe1_stall = 1; de_setpc = 1; de_newpc = 30'h600;
    settle();
    n_tests++;
    if (fe0_read_req !== 1'b0 || fe0_read_addr !== 30'h500) begin
      n_fail++;
      $display("FAIL de_behind_csr: req=%b addr=%h required req=0 addr=500", fe0_read_req, fe0_read_addr);
    end
    tick();
    idle_inputs();
    settle();
    n_tests++;
    if (fe0_read_req !== 1'b1 || fe0_read_addr !== 30'h500) begin
      n_fail++;
      $display("FAIL csr_pending_issue: req=%b addr=%h required req=1 addr=500", fe0_read_req, fe0_read_addr);
    end
    tick();
  endtask

  task automatic test_fencei();
    int next_set, cyc;
    bit phase;
    idle_inputs();
    csr_fencei = 1; csr_fencei_pc = 30'h200;
    settle();
    n_tests++;
    if (fe0_read_req !== 1'b0) begin
      n_fail++;
      $display("FAIL fencei_noissue: req=%b required 0", fe0_read_req);
    end
    tick();
    csr_fencei = 0;
    next_set = 0; cyc = 0; phase = 0;
    while (next_set < IC_SETS && cyc < 40) begin
      ic_inv_ack = phase;
      settle();
      n_tests++;
      if (ic_inv_req !== 1'b1 || fencei_busy !== 1'b1 || fe0_read_req !== 1'b0 || ic_inv_set !== SW'(next_set)) begin
        n_fail++;
        $display("FAIL fencei_flush: inv=%b busy=%b req=%b set=%0d required inv=1 busy=1 req=0 set=%0d",
                 ic_inv_req, fencei_busy, fe0_read_req, ic_inv_set, next_set);
      end
      if (phase) next_set++;
      phase = !phase;
      cyc++;
      tick();
    end
    n_tests++;
    if (next_set != IC_SETS) begin
      n_fail++;
      $display("FAIL fencei_timeout: walked %0d sets required %0d", next_set, IC_SETS);
    end
    ic_inv_ack = 0;
    settle();
    n_tests++;
    if (fe0_read_req !== 1'b0 || fencei_busy !== 1'b1 || ic_inv_req !== 1'b0) begin
      n_fail++;
      $display("FAIL fencei_resume: req=%b busy=%b inv=%b required req=0 busy=1 inv=0",
               fe0_read_req, fencei_busy, ic_inv_req);
    end
    tick();
    settle();
    n_tests++;
    if (fe0_read_req !== 1'b1 || fe0_read_addr !== 30'h200 || fencei_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fencei_restart: req=%b addr=%h busy=%b required req=1 addr=200 busy=0",
               fe0_read_req, fe0_read_addr, fencei_busy);
    end
    tick();
  endtask

  task automatic test_inhibit();
    idle_inputs();
    csr_fe_inhibit = 1; csr_kill_setpc = 1; csr_newpc = 30'h300;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_tests++;
      if (fe0_read_req !== 1'b0) begin
        n_fail++;
        $display("FAIL inhibit_noreq[%0d]: req=%b required 0", i, fe0_read_req);
      end
      tick();
      csr_kill_setpc = 0;
    end
    csr_fe_inhibit = 0;
    settle();
    n_tests++;
    if (fe0_read_req !== 1'b1 || fe0_read_addr !== 30'h300) begin
      n_fail++;
      $display("FAIL inhibit_release: req=%b addr=%h required req=1 addr=300", fe0_read_req, fe0_read_addr);
    end
    tick();
  endtask

  task automatic test_reset_mid_flush();
    idle_inputs();
    csr_fencei = 1; csr_fencei_pc = 30'h2A0;
    settle();
    tick();
    csr_fencei = 0;
    for (int i = 0; i < 3; i++) begin settle(); tick(); end
    reset_n = 0;
    #1;
    n_tests++;
    if (ic_inv_req !== 1'b0 || fencei_busy !== 1'b0 || fe0_read_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_flush: inv=%b busy=%b req=%b required all 0", ic_inv_req, fencei_busy, fe0_read_req);
    end
    tick();
    reset_n = 1;
    model_reset();
    settle();
    n_tests++;
    if (fe0_read_req !== 1'b1 || fe0_read_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_restart: req=%b addr=%h required req=1 addr=%h", fe0_read_req, fe0_read_addr, RST_PC);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      fe1_stall      = ($urandom_range(0, 1) == 0);
      de_setpc       = ($urandom_range(0, 3) == 0);
      csr_kill_setpc = ($urandom_range(0, 9) == 0);
      csr_fe_inhibit = ($urandom_range(0, 9) == 0);
      csr_fencei     = ($urandom_range(0, 29) == 0);
      ic_inv_ack     = ($urandom_range(0, 1) == 0);
      de_newpc       = 30'($urandom());
      csr_newpc      = 30'($urandom());
      csr_fencei_pc  = 30'($urandom());
      csr_satp       = $urandom();
      settle();
      n_tests++;
      if (fe0_read_req !== e_req || fe0_valid !== e_req || (e_req && fe0_read_addr !== e_addr)) begin
        n_fail++;
        $display("FAIL rand_issue[%0d]: req=%b valid=%b addr=%h required req=%b addr=%h",
                 i, fe0_read_req, fe0_valid, fe0_read_addr, e_req, e_addr);
      end
      n_tests++;
      if (ic_inv_req !== e_inv || fencei_busy !== e_busy || (e_inv && ic_inv_set !== SW'(e_set))) begin
        n_fail++;
        $display("FAIL rand_flush[%0d]: inv=%b set=%0d busy=%b required inv=%b set=%0d busy=%b",
                 i, ic_inv_req, ic_inv_set, fencei_busy, e_inv, e_set, e_busy);
      end
      n_tests++;
      if (fe0_read_asid !== csr_satp[30:22]) begin
        n_fail++;
        $display("FAIL rand_asid[%0d]: got %h required %h", i, fe0_read_asid, csr_satp[30:22]);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential_wrap();
    test_stall_redirect();
    test_csr_priority();
    test_fencei();
    test_inhibit();
    test_reset_mid_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
